// File: rtl/hamming_decoder64_pipe.sv
// rtl/hamming_decoder64_pipe.sv - two-stage SECDED decoder for 72-bit Hamming codewords, saturating error counters
// Optional syndrome_out/ovp_out observation ports: HAMMING_DEC_SYNDROME_OUT_EN
module hamming_decoder64_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [71:0]      codeword_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      data_out,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
    ,
    output logic [6:0]       syndrome_out,
    output logic             ovp_out
`endif
);

    function automatic logic [71:0] syn_mask(input int k);
        logic [71:0] m;
        m = '0;
        for (int i = 1; i < 72; i++) begin
            if (((i >> k) & 1) == 1) begin
                m = m | (72'd1 << i);
            end
        end
        return m;
    endfunction

    function automatic int data_pos(input int d);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == d) begin
                    pos = p;
                end
                n++;
            end
        end
        return pos;
    endfunction

    logic             w_en;
    logic [6:0]       w_syn;
    logic             w_ovp;
    logic [63:0]      w_raw;
    logic [63:0]      w_data;
    logic             w_corr;
    logic             w_uncorr;
    logic             w_flip;

    logic             r_s1_valid;
    logic [63:0]      r_s1_raw;
    logic [6:0]       r_s1_syn;
    logic             r_s1_ovp;

    logic             r_out_valid;
    logic [63:0]      r_data;
    logic             r_corr;
    logic             r_uncorr;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < 7; k++) begin : g_syn
        localparam logic [71:0] MASK = syn_mask(k);
        assign w_syn[k] = ^(codeword_in & MASK);
    end

    assign w_ovp = ^codeword_in;

    // Check-bit positions are fully summarised by syndrome/ovp, so only data positions travel on.
    for (genvar d = 0; d < 64; d++) begin : g_data
        localparam int          POS   = data_pos(d);
        localparam logic [6:0]  POS_7 = 7'(POS);
        assign w_raw[d]  = codeword_in[POS];
        assign w_data[d] = r_s1_raw[d] ^ (w_flip && (r_s1_syn == POS_7));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_syn   <= '0;
            r_s1_ovp   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_raw   <= w_raw;
            r_s1_syn   <= w_syn;
            r_s1_ovp   <= w_ovp;
        end
    end

    always_comb begin
        w_corr   = 1'b0;
        w_uncorr = 1'b0;
        w_flip   = 1'b0;
        if (r_s1_syn == 7'd0) begin
            w_corr = r_s1_ovp;
        end else if (!r_s1_ovp || (r_s1_syn >= 7'd72)) begin
            w_uncorr = 1'b1;
        end else begin
            w_corr = 1'b1;
            w_flip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_corr      <= 1'b0;
            r_uncorr    <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            r_data      <= w_data;
            r_corr      <= r_s1_valid && w_corr;
            r_uncorr    <= r_s1_valid && w_uncorr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_en && r_s1_valid) begin
            if (w_corr && (r_corr_cnt != {CNT_W{1'b1}})) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (w_uncorr && (r_uncorr_cnt != {CNT_W{1'b1}})) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HAMMING_DEC_SYNDROME_OUT_EN
    logic [6:0] r_syn_out;
    logic       r_ovp_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syn_out <= '0;
            r_ovp_out <= 1'b0;
        end else if (w_en) begin
            r_syn_out <= r_s1_syn;
            r_ovp_out <= r_s1_ovp;
        end
    end

    assign syndrome_out = r_syn_out;
    assign ovp_out      = r_ovp_out;
`endif

    assign out_valid         = r_out_valid;
    assign data_out          = r_data;
    assign err_corrected     = r_corr;
    assign err_uncorrectable = r_uncorr;
    assign corr_cnt          = r_corr_cnt;
    assign uncorr_cnt        = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_decoder64_pipe.sv
// tb/tb_hamming_decoder64_pipe.sv - scoreboard bench for hamming_decoder64_pipe (16-bit and 2-bit counter instances)
module tb_hamming_decoder64_pipe;

    typedef struct {
        logic [63:0] data;
        logic        corr;
        logic        uncorr;
        logic [6:0]  syn;
        logic        ovp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [71:0] codeword_in;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready, out_valid, err_corrected, err_uncorrectable;
    logic [63:0] data_out;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        s_in_ready, s_out_valid, s_corr, s_uncorr;
    logic [63:0] s_data;
    logic [1:0]  s_corr_cnt, s_uncorr_cnt;

`ifdef HAMMING_DEC_SYNDROME_OUT_EN
    logic [6:0]  syndrome_out, s_syndrome_out;
    logic        ovp_out, s_ovp_out;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hamming_decoder64_pipe #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err_corrected(err_corrected),
        .err_uncorrectable(err_uncorrectable), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
        , .syndrome_out(syndrome_out), .ovp_out(ovp_out)
`endif
    );

    hamming_decoder64_pipe #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .codeword_in(codeword_in), .out_valid(s_out_valid), .out_ready(out_ready),
        .data_out(s_data), .err_corrected(s_corr),
        .err_uncorrectable(s_uncorr), .cnt_clr(cnt_clr),
        .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
        , .syndrome_out(s_syndrome_out), .ovp_out(s_ovp_out)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the word has been accepted.
    task automatic send(input logic [71:0] cw, input logic [63:0] data, input logic corr,
                        input logic uncorr, input logic [6:0] syn, input logic ovp);
        exp_t e;
        logic ok;
        int   t;
        e.data = data; e.corr = corr; e.uncorr = uncorr; e.syn = syn; e.ovp = ovp;
        in_valid    = 1'b1;
        codeword_in = cw;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) sb.push_back(e);
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag, input logic [15:0] c, input logic [15:0] u,
                              input logic [1:0] sc, input logic [1:0] su);
        check({tag, "_corr_cnt"}, 64'(corr_cnt), 64'(c));
        check({tag, "_uncorr_cnt"}, 64'(uncorr_cnt), 64'(u));
        check({tag, "_sat_corr_cnt"}, 64'(s_corr_cnt), 64'(sc));
        check({tag, "_sat_uncorr_cnt"}, 64'(s_uncorr_cnt), 64'(su));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data %0h, required no output", data_out);
            end else begin
                mon_e = sb.pop_front();
                check("data_out", data_out, mon_e.data);
                check("err_corrected", 64'(err_corrected), 64'(mon_e.corr));
                check("err_uncorrectable", 64'(err_uncorrectable), 64'(mon_e.uncorr));
                check("sat_data_out", s_data, mon_e.data);
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
                check("syndrome_out", 64'(syndrome_out), 64'(mon_e.syn));
                check("ovp_out", 64'(ovp_out), 64'(mon_e.ovp));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; codeword_in = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_data_out", data_out, 64'd0);
        check("rst_flags", 64'({err_corrected, err_uncorrectable}), 64'd0);
        check_cnts("rst", 16'd0, 16'd0, 2'd0, 2'd0);
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
        check("rst_syndrome", 64'({ovp_out, syndrome_out}), 64'd0);
`endif
        @(posedge clk);
        #1;

        // clean words
        send(72'h0, 64'h0, 1'b0, 1'b0, 7'd0, 1'b0);
        send(72'h0F, 64'h1, 1'b0, 1'b0, 7'd0, 1'b0);
        drain();
        check_cnts("clean", 16'd0, 16'd0, 2'd0, 2'd0);

        // single, bit-0, double, invalid-syndrome, high-position errors
        send(72'h07, 64'h1, 1'b1, 1'b0, 7'd3, 1'b1);
        send(72'h1, 64'h0, 1'b1, 1'b0, 7'd0, 1'b1);
        send(72'h220, 64'h12, 1'b0, 1'b1, 7'd12, 1'b0);
        send(72'h01_0000_0000_0000_0102, 64'h0, 1'b0, 1'b1, 7'd73, 1'b1);
        send(72'h81_0000_0000_0000_0017, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 7'd0, 1'b0);
        send(72'h01_0000_0000_0000_0017, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 7'd71, 1'b1);
        send(72'h80_0000_0000_0000_0017, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 7'd64, 1'b1);
        send(72'h07, 64'h1, 1'b1, 1'b0, 7'd3, 1'b1);
        drain();
        check_cnts("errs", 16'd5, 16'd2, 2'd3, 2'd2);

        // clear coincides with stage2 loading a correctable word
        send(72'h07, 64'h1, 1'b1, 1'b0, 7'd3, 1'b1);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        drain();
        check_cnts("clr", 16'd0, 16'd0, 2'd0, 2'd0);

        // backpressure
        fork
            begin
                send(72'h0F, 64'h1, 1'b0, 1'b0, 7'd0, 1'b0);
                send(72'h81_0000_0000_0000_0017, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 7'd0, 1'b0);
                send(72'h220, 64'h12, 1'b0, 1'b1, 7'd12, 1'b0);
                send(72'h1, 64'h0, 1'b1, 1'b0, 7'd0, 1'b1);
                in_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (!out_valid && t < 50);
                check("bp_first_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_out_valid", 64'(out_valid), 64'd1);
                    check("bp_data_held", data_out, 64'h1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_cnts("bp", 16'd1, 16'd1, 2'd1, 2'd1);

        // reset mid-stream discards in-flight words
        send(72'h0F, 64'h1, 1'b0, 1'b0, 7'd0, 1'b0);
        send(72'h07, 64'h1, 1'b1, 1'b0, 7'd3, 1'b1);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_flags", 64'({err_corrected, err_uncorrectable}), 64'd0);
        check_cnts("mid_rst", 16'd0, 16'd0, 2'd0, 2'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_quiet", 64'(out_valid), 64'd0);
        check_cnts("post_rst", 16'd0, 16'd0, 2'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
